// File: rtl/clock_set_ctrl.sv
// Time-setting controller: debounces the mode/increment buttons and runs the
// RUN / SET_HOUR / SET_MIN editor that commits shadow time to the clock core.
module clock_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 10000000,
  parameter int TIMEOUT_S       = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn0_n,
  input  logic       btn1_n,
  input  logic       s_tick,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  output logic [4:0] edit_hour,
  output logic [5:0] edit_min,
  output logic       load,
  output logic       editing,
  output logic       sel_h,
  output logic       sel_m
);

  localparam int CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam int TW   = (TIMEOUT_S > 1) ? $clog2(TIMEOUT_S) : 1;

  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] HOLD_LAST  = RW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] RPT_LAST   = RW'(REPEAT_CYCLES - 1);
  localparam logic [TW-1:0] IDLE_LAST  = TW'(TIMEOUT_S - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } state_t;

  state_t          state;
  logic [1:0]      raw;
  logic [1:0]      sync0;
  logic [1:0]      sync1;
  logic [1:0]      pressed;
  logic [1:0]      level;
  logic [1:0]      level_d;
  logic [1:0]      press;
  logic [CW-1:0]   db_cnt [2];
  logic [RW-1:0]   rep_cnt;
  logic            repeating;
  logic            btn1_held;
  logic            rep_fire;
  logic            inc;
  logic [TW-1:0]   idle_cnt;
  logic [4:0]      hour_next;
  logic [5:0]      min_next;

  assign raw = {btn1_n, btn0_n};

  // Synchronizers idle at the released (high) raw level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0 <= 2'b11;
      sync1 <= 2'b11;
    end else begin
      sync0 <= raw;
      sync1 <= sync0;
    end
  end

  assign pressed = ~sync1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level   <= 2'b00;
      level_d <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      level_d <= level;
      for (int i = 0; i < 2; i++) begin
        if (pressed[i] != level[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            level[i]  <= pressed[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + CW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign press     = level & ~level_d;
  assign btn1_held = level[1] & level_d[1];

  // Repeat counter starts at the press pulse; first target is the hold delay.
  assign rep_fire = btn1_held &&
                    (rep_cnt == (repeating ? RPT_LAST : HOLD_LAST));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_cnt   <= '0;
      repeating <= 1'b0;
    end else if (!btn1_held) begin
      rep_cnt   <= '0;
      repeating <= 1'b0;
    end else if (rep_fire) begin
      rep_cnt   <= '0;
      repeating <= 1'b1;
    end else begin
      rep_cnt   <= rep_cnt + RW'(1);
    end
  end

  assign inc       = press[1] | rep_fire;
  assign hour_next = (edit_hour >= 5'd23) ? 5'd0 : edit_hour + 5'd1;
  assign min_next  = (edit_min >= 6'd59) ? 6'd0 : edit_min + 6'd1;

  // btn0 is checked first so it wins over a simultaneous increment or tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      edit_hour <= 5'd0;
      edit_min  <= 6'd0;
      load      <= 1'b0;
      editing   <= 1'b0;
      sel_h     <= 1'b0;
      sel_m     <= 1'b0;
      idle_cnt  <= '0;
    end else begin
      load <= 1'b0;
      case (state)
        RUN: begin
          idle_cnt <= '0;
          if (press[0]) begin
            state     <= SET_HOUR;
            edit_hour <= cur_hour;
            edit_min  <= cur_min;
            editing   <= 1'b1;
            sel_h     <= 1'b1;
            sel_m     <= 1'b0;
          end
        end

        SET_HOUR: begin
          if (press[0]) begin
            state    <= SET_MIN;
            sel_h    <= 1'b0;
            sel_m    <= 1'b1;
            idle_cnt <= '0;
          end else if (inc) begin
            edit_hour <= hour_next;
            idle_cnt  <= '0;
          end else if (s_tick) begin
            if (idle_cnt == IDLE_LAST) begin
              state    <= RUN;
              editing  <= 1'b0;
              sel_h    <= 1'b0;
              idle_cnt <= '0;
            end else begin
              idle_cnt <= idle_cnt + TW'(1);
            end
          end
        end

        SET_MIN: begin
          if (press[0]) begin
            state    <= RUN;
            load     <= 1'b1;
            editing  <= 1'b0;
            sel_m    <= 1'b0;
            idle_cnt <= '0;
          end else if (inc) begin
            edit_min <= min_next;
            idle_cnt <= '0;
          end else if (s_tick) begin
            if (idle_cnt == IDLE_LAST) begin
              state    <= RUN;
              editing  <= 1'b0;
              sel_m    <= 1'b0;
              idle_cnt <= '0;
            end else begin
              idle_cnt <= idle_cnt + TW'(1);
            end
          end
        end

        default: begin
          state    <= RUN;
          editing  <= 1'b0;
          sel_h    <= 1'b0;
          sel_m    <= 1'b0;
          idle_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl using the short simulation parameters.
module tb_clock_set_ctrl;

  logic       clk;
  logic       reset;
  logic       btn0_n;
  logic       btn1_n;
  logic       s_tick;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;
  logic [4:0] edit_hour;
  logic [5:0] edit_min;
  logic       load;
  logic       editing;
  logic       sel_h;
  logic       sel_m;

  int checks = 0;
  int errors = 0;

  clock_set_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES(20),
    .REPEAT_CYCLES(8),
    .TIMEOUT_S(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn0_n(btn0_n),
    .btn1_n(btn1_n),
    .s_tick(s_tick),
    .cur_hour(cur_hour),
    .cur_min(cur_min),
    .edit_hour(edit_hour),
    .edit_min(edit_min),
    .load(load),
    .editing(editing),
    .sel_h(sel_h),
    .sel_m(sel_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Clean press: buttons low for 10 cycles, then released for 10.
  task automatic applyStimulus(input bit b0, input bit b1);
    btn0_n = ~b0;
    btn1_n = ~b1;
    tick(10);
    btn0_n = 1'b1;
    btn1_n = 1'b1;
    tick(10);
  endtask

  task automatic commitCheck(input string tag, input int hour, input int min);
    btn0_n = 1'b0;
    tick(6);
    checkOutput({tag, "_load_before"}, load, 0);
    checkOutput({tag, "_editing_before"}, editing, 1);
    tick(1);
    checkOutput({tag, "_load_pulse"}, load, 1);
    checkOutput({tag, "_editing_drop"}, editing, 0);
    checkOutput({tag, "_sel_m_drop"}, sel_m, 0);
    checkOutput({tag, "_load_hour"}, edit_hour, hour);
    checkOutput({tag, "_load_min"}, edit_min, min);
    tick(1);
    checkOutput({tag, "_load_single"}, load, 0);
    checkOutput({tag, "_hold_hour"}, edit_hour, hour);
    checkOutput({tag, "_hold_min"}, edit_min, min);
    tick(2);
    btn0_n = 1'b1;
    tick(10);
  endtask

  initial begin
    reset    = 1'b1;
    btn0_n   = 1'b1;
    btn1_n   = 1'b1;
    s_tick   = 1'b0;
    cur_hour = 5'd13;
    cur_min  = 6'd45;
    tick(3);
    checkOutput("rst_editing", editing, 0);
    checkOutput("rst_load", load, 0);
    checkOutput("rst_hour", edit_hour, 0);
    checkOutput("rst_min", edit_min, 0);
    reset = 1'b0;
    tick(3);

    $display("[TB] full set sequence");
    applyStimulus(1, 0);
    checkOutput("seq_sel_h", sel_h, 1);
    checkOutput("seq_editing", editing, 1);
    checkOutput("seq_cap_hour", edit_hour, 13);
    checkOutput("seq_cap_min", edit_min, 45);
    applyStimulus(0, 1);
    applyStimulus(0, 1);
    checkOutput("seq_hour15", edit_hour, 15);
    applyStimulus(1, 0);
    checkOutput("seq_sel_m", sel_m, 1);
    checkOutput("seq_sel_h_off", sel_h, 0);
    applyStimulus(0, 1);
    checkOutput("seq_min46", edit_min, 46);
    commitCheck("seq", 15, 46);
    applyStimulus(0, 1);
    checkOutput("run_ignore_btn1", edit_hour, 15);

    $display("[TB] wrap");
    cur_hour = 5'd23;
    cur_min  = 6'd59;
    applyStimulus(1, 0);
    applyStimulus(0, 1);
    checkOutput("wrap_hour", edit_hour, 0);
    applyStimulus(1, 0);
    applyStimulus(0, 1);
    checkOutput("wrap_min", edit_min, 0);
    commitCheck("wrap", 0, 0);

    $display("[TB] bounce rejection");
    cur_hour = 5'd5;
    cur_min  = 6'd10;
    btn0_n = 1'b0; tick(3);
    btn0_n = 1'b1; tick(2);
    btn0_n = 1'b0; tick(3);
    btn0_n = 1'b1; tick(15);
    checkOutput("bounce_no_edit", editing, 0);
    btn0_n = 1'b0;
    tick(6);
    checkOutput("deb_not_yet", editing, 0);
    tick(1);
    checkOutput("deb_latency", editing, 1);
    checkOutput("deb_sel_h", sel_h, 1);
    tick(5);
    btn0_n = 1'b1;
    tick(15);
    checkOutput("deb_single", sel_h, 1);

    $display("[TB] auto-repeat");
    applyStimulus(1, 0);
    checkOutput("rpt_sel_m", sel_m, 1);
    checkOutput("rpt_start", edit_min, 10);
    btn1_n = 1'b0;
    tick(7);
    checkOutput("rpt_press", edit_min, 11);
    tick(19);
    checkOutput("rpt_hold_wait", edit_min, 11);
    tick(1);
    checkOutput("rpt_first", edit_min, 12);
    tick(13);
    btn1_n = 1'b1;
    tick(3);
    checkOutput("rpt_third", edit_min, 14);
    tick(15);
    checkOutput("rpt_final", edit_min, 14);
    commitCheck("rpt", 5, 14);

    $display("[TB] timeout and priority");
    cur_hour = 5'd8;
    cur_min  = 6'd20;
    applyStimulus(1, 0);
    checkOutput("to_sel_h", sel_h, 1);
    for (int t = 0; t < 2; t++) begin
      s_tick = 1'b1; tick(1);
      s_tick = 1'b0; tick(3);
    end
    checkOutput("to_still_edit", editing, 1);
    s_tick = 1'b1; tick(1);
    s_tick = 1'b0;
    checkOutput("to_exit", editing, 0);
    checkOutput("to_no_load", load, 0);
    tick(1);
    checkOutput("to_no_load_late", load, 0);
    checkOutput("to_keep_hour", edit_hour, 8);
    applyStimulus(1, 0);
    applyStimulus(1, 1);
    checkOutput("prio_sel_m", sel_m, 1);
    checkOutput("prio_hour", edit_hour, 8);
    checkOutput("prio_min", edit_min, 20);
    commitCheck("prio", 8, 20);

    $display("[TB] reset mid-edit");
    cur_hour = 5'd7;
    cur_min  = 6'd30;
    applyStimulus(1, 0);
    applyStimulus(1, 0);
    checkOutput("mid_sel_m", sel_m, 1);
    checkOutput("mid_hour", edit_hour, 7);
    checkOutput("mid_min", edit_min, 30);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("arst_editing", editing, 0);
    checkOutput("arst_sel_m", sel_m, 0);
    checkOutput("arst_hour", edit_hour, 0);
    checkOutput("arst_min", edit_min, 0);
    tick(2);
    #2;
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick(1);
      checkOutput("post_rst_load", load, 0);
    end
    checkOutput("post_rst_editing", editing, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
